// File: rtl/mvm_pkg.sv
// Shared definitions for the streaming matrix-vector multiplier:
// FSM state encoding, counter sizing and the saturating add used when
// MVM_SATURATE_EN is defined.
package mvm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Saturating arithmetic is evaluated in 64 bits, which bounds ACC_WIDTH.
  localparam int SAT_MAX_ACC_WIDTH = 62;

  // Column counter width: clog2(cols), never below one bit.
  function automatic int cnt_width(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  // a + b clamped to the signed range of an acc_w-bit value.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int acc_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] sum;
    hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sum = a + b;
    if (sum > hi) return hi;
    else if (sum < lo) return lo;
    else return sum;
  endfunction

endpackage

// File: rtl/mvm_stream_mac_lane.sv
// One signed multiply-accumulate lane. clear zeroes the accumulator,
// en adds a*b (full-width product, sign-extended). acc_next is the value
// the accumulator takes on an enabled edge, so the parent can register the
// final sum on the same edge as the last term.
// MVM_SATURATE_EN: clamp every step and track a sticky saturation bit.
module mac_lane
  import mvm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] acc_next
`ifdef MVM_SATURATE_EN
  ,
  output logic                        sat_next
`endif
);

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;

`ifdef MVM_SATURATE_EN
  logic                        sat;
  logic signed [63:0]          sum_clamped;

  // Clamped step; the lane has saturated if clamping changed the sum.
  always_comb begin
    prod        = a * b;
    prod_ext    = ACC_WIDTH'(prod);
    sum_clamped = sat_add(64'(acc), 64'(prod_ext), ACC_WIDTH);
    acc_next    = sum_clamped[ACC_WIDTH-1:0];
    sat_next    = sat || (sum_clamped != (64'(acc) + 64'(prod_ext)));
  end

  // Sticky saturation bit, cleared with the accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sat <= 1'b0;
    else if (clear) sat <= 1'b0;
    else if (en)    sat <= sat_next;
  end
`else
  // Wrapping step: the add simply drops carries beyond ACC_WIDTH.
  always_comb begin
    prod     = a * b;
    prod_ext = ACC_WIDTH'(prod);
    acc_next = acc + prod_ext;
  end
`endif

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc_next;
  end

endmodule

// File: rtl/mvm_stream.sv
// Streaming signed matrix-vector multiplier, result = M x v.
// One column per cycle over ROWS parallel MAC lanes; one transaction per
// COLS+2 cycles when the output is never stalled.
// Optional feature macro: MVM_SATURATE_EN (saturating accumulate + sat_flag).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// OUT, and result (and sat_flag) stay stable until out_ready is seen.
module mvm_stream
  import mvm_pkg::*;
#(
  parameter int ROWS      = 6,
  parameter int COLS      = 3,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*COLS*WIDTH-1:0]    matrix,
  input  logic [COLS*WIDTH-1:0]         vector,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS*ACC_WIDTH-1:0]     result,
  output logic                          busy
`ifdef MVM_SATURATE_EN
  ,
  output logic [ROWS-1:0]               sat_flag
`endif
);

  localparam int CW = cnt_width(COLS);

  if (ACC_WIDTH < 2*WIDTH) begin : g_acc_too_narrow
    $error("mvm_stream: ACC_WIDTH must be >= 2*WIDTH");
  end
`ifdef MVM_SATURATE_EN
  if (ACC_WIDTH > SAT_MAX_ACC_WIDTH) begin : g_acc_too_wide
    $error("mvm_stream: ACC_WIDTH too wide for saturating accumulate");
  end
`endif

  state_t                      state_q;
  state_t                      state_d;
  logic [CW-1:0]               cnt_q;
  logic [ROWS*COLS*WIDTH-1:0]  m_q;
  logic [COLS*WIDTH-1:0]       v_q;
  logic                        accept;
  logic                        in_mac;
  logic                        last_col;
  logic signed [WIDTH-1:0]     m_sel [ROWS];
  logic signed [WIDTH-1:0]     v_sel;
  logic signed [ACC_WIDTH-1:0] acc_next [ROWS];
`ifdef MVM_SATURATE_EN
  logic [ROWS-1:0]             sat_next;
`endif

  assign accept   = in_valid && (state_q == ST_IDLE);
  assign in_mac   = (state_q == ST_MAC);
  assign last_col = (cnt_q == CW'(COLS - 1));

  // Next state and handshake/status outputs, all decoded from state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ST_MAC;
      end
      ST_MAC: begin
        if (last_col) state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Column counter: restarts on accept, steps once per MAC edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (accept) cnt_q <= '0;
    else if (in_mac) cnt_q <= last_col ? '0 : cnt_q + CW'(1);
  end

  // Operand capture so the upstream buffers are free after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      v_q <= '0;
    end else if (accept) begin
      m_q <= matrix;
      v_q <= vector;
    end
  end

  // Column select: vector element and each row's matrix element for column cnt_q.
  always_comb begin
    v_sel = '0;
    for (int r = 0; r < ROWS; r++) m_sel[r] = '0;
    for (int c = 0; c < COLS; c++) begin
      if (cnt_q == CW'(c)) begin
        v_sel = v_q[c*WIDTH +: WIDTH];
        for (int r = 0; r < ROWS; r++) m_sel[r] = m_q[(r*COLS + c)*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    mac_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .en       (in_mac),
      .a        (m_sel[r]),
      .b        (v_sel),
      .acc_next (acc_next[r])
`ifdef MVM_SATURATE_EN
      ,
      .sat_next (sat_next[r])
`endif
    );
  end

  // Result capture on the last MAC edge, including the final column's term.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
    end else if (in_mac && last_col) begin
      for (int r = 0; r < ROWS; r++) result[r*ACC_WIDTH +: ACC_WIDTH] <= acc_next[r];
    end
  end

`ifdef MVM_SATURATE_EN
  // Per-lane saturation summary, captured alongside result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 sat_flag <= '0;
    else if (in_mac && last_col) sat_flag <= sat_next;
  end
`endif

endmodule

// File: tb/tb_mvm_stream.sv
// Self-checking bench for mvm_stream: directed cases, backpressure, reset
// mid-transaction, streaming throughput, and randomized traffic compared
// with a plain-arithmetic reference model through an expected-result queue.
module tb_mvm_stream;

  localparam int R  = 2;
  localparam int C  = 3;
  localparam int W  = 8;
  localparam int AW = 20;
  localparam int WAW = 16;
`ifdef MVM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [R*C*W-1:0]   matrix;
  logic [C*W-1:0]     vector;
  logic               out_valid;
  logic               out_ready;
  logic [R*AW-1:0]    result;
  logic               busy;

  logic               w_in_valid;
  logic               w_in_ready;
  logic [C*W-1:0]     w_matrix;
  logic [C*W-1:0]     w_vector;
  logic               w_out_valid;
  logic               w_out_ready;
  logic [WAW-1:0]     w_result;
  logic               w_busy;
`ifdef MVM_SATURATE_EN
  logic [R-1:0]       sat_flag;
  logic [0:0]         w_sat_flag;
`endif

  mvm_stream #(.ROWS(R), .COLS(C), .WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .matrix(matrix), .vector(vector), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
`ifdef MVM_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  mvm_stream #(.ROWS(1), .COLS(C), .WIDTH(W), .ACC_WIDTH(WAW)) dut_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .matrix(w_matrix), .vector(w_vector), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .result(w_result), .busy(w_busy)
`ifdef MVM_SATURATE_EN
    , .sat_flag(w_sat_flag)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [R*AW-1:0] exp_q[$];
  logic [R-1:0]    exp_sat_q[$];
  int              acc_cyc_q[$];
  int              hs_q[$];
  bit              stream_mode = 1'b0;
  bit              ov_prev = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: sum of products per row, then either wrap to aw bits or
  // clamp after every term when saturation is enabled.
  function automatic longint ref_row(input longint terms[$], input int aw,
                                     input bit sat_mode, output bit sat);
    longint hi, lo, s, span;
    hi   = (64'sd1 <<< (aw - 1)) - 1;
    lo   = -hi - 1;
    span = 64'sd1 <<< aw;
    sat  = 1'b0;
    s    = 0;
    if (sat_mode) begin
      foreach (terms[i]) begin
        s += terms[i];
        if (s > hi) begin s = hi; sat = 1'b1; end
        else if (s < lo) begin s = lo; sat = 1'b1; end
      end
    end else begin
      foreach (terms[i]) s += terms[i];
      s = s & (span - 1);
      if (s > hi) s -= span;
    end
    return s;
  endfunction

  function automatic logic [R*AW-1:0] model(input logic [R*C*W-1:0] m,
                                           input logic [C*W-1:0] v,
                                           output logic [R-1:0] sflags);
    logic [R*AW-1:0] res;
    longint terms[$];
    longint x;
    bit st;
    res = '0;
    sflags = '0;
    for (int r = 0; r < R; r++) begin
      terms.delete();
      for (int c = 0; c < C; c++)
        terms.push_back(longint'($signed(m[(r*C+c)*W +: W])) * longint'($signed(v[c*W +: W])));
      x = ref_row(terms, AW, SAT, st);
      res[r*AW +: AW] = x[AW-1:0];
      sflags[r] = st;
    end
    return res;
  endfunction

  // ---------------- monitor ----------------
  // Pushes the expectation at each input transfer and pops it at each
  // output transfer; also checks output latency and status during OUT.
  always @(negedge clk) begin
    logic [R*AW-1:0] e;
    logic [R-1:0]    es;
    int a;
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e = model(matrix, vector, es);
        exp_q.push_back(e);
        exp_sat_q.push_back(es);
        acc_cyc_q.push_back(cyc + 1);
      end
      if (out_valid && !ov_prev) begin
        if (acc_cyc_q.size() == 0) check("latency_no_accept", 64'd1, 64'd0);
        else begin
          a = acc_cyc_q.pop_front();
          check("latency", 64'(cyc - a), 64'(C));
        end
        check("in_ready_during_out", 64'(in_ready), 64'd0);
        check("busy_during_out", 64'(busy), 64'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
        else begin
          e  = exp_q.pop_front();
          es = exp_sat_q.pop_front();
          check("result", 64'(result), 64'(e));
`ifdef MVM_SATURATE_EN
          check("sat_flag", 64'(sat_flag), 64'(es));
`endif
        end
        if (stream_mode) hs_q.push_back(cyc);
      end
      ov_prev = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int mv[R*C], input int vv[C]);
    for (int i = 0; i < R*C; i++) matrix[i*W +: W] = W'(mv[i]);
    for (int i = 0; i < C; i++) vector[i*W +: W] = W'(vv[i]);
  endtask

  task automatic rand_ops();
    int x;
    for (int i = 0; i < R*C + C; i++) begin
      case ($urandom_range(0, 5))
        0: x = -128;
        1: x = 127;
        default: x = int'($urandom_range(0, 255)) - 128;
      endcase
      if (i < R*C) matrix[i*W +: W] = W'(x);
      else vector[(i-R*C)*W +: W] = W'(x);
    end
  endtask

  // Returns #1 after the posedge on which the operands were accepted.
  task automatic wait_accept();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin check("accept_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic send();
    @(posedge clk); #1;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_in_mac", 64'(in_ready), 64'd0);
  endtask

  task automatic drain(input bit random_bp);
    int n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      out_ready = random_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      n++;
      if (n > 300) begin check("drain_timeout", 64'(exp_q.size()), 64'd0); break; end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  logic [R*AW-1:0] held;
  logic [R*AW-1:0] k15_6;
  logic [R*AW-1:0] k_ext;
  bit saw_ov;
  int n;

  initial begin
    k15_6 = {20'd15, 20'd6};
    k_ext = {20'(-16128), 20'(49152)};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    matrix = '0; vector = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_matrix = {C{8'h80}}; w_vector = {C{8'h80}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // case 1 and signed extremes
    set_ops('{1, 2, 3, 4, 5, 6}, '{1, 1, 1});
    send(); drain(0);
    check("case1_const", 64'(result), 64'(k15_6));
    set_ops('{-128, -128, -128, 127, -1, 0}, '{-128, -128, -128});
    send(); drain(0);
    check("case2_const", 64'(result), 64'(k_ext));

    // narrow accumulator: wrap by default, clamp with saturation
    @(posedge clk); #1 w_in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (w_in_ready) break;
      n++;
      if (n > 50) begin check("w_accept_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge clk); #1 w_in_valid = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (w_out_valid) break;
      n++;
      if (n > 50) begin check("w_out_timeout", 64'd0, 64'd1); break; end
    end
    check("narrow_result", 64'(w_result), SAT ? 64'h7FFF : 64'hC000);
`ifdef MVM_SATURATE_EN
    check("narrow_sat_flag", 64'(w_sat_flag), 64'd1);
`endif

    // backpressure with new operands offered while stalled
    out_ready = 1'b0;
    set_ops('{1, 2, 3, 4, 5, 6}, '{1, 1, 1});
    send();
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_out_valid_seen", 64'(out_valid), 64'd1);
    set_ops('{-128, -128, -128, 127, -1, 0}, '{-128, -128, -128});
    in_valid = 1'b1;
    held = result;
    check("bp_held_value", 64'(held), 64'(k15_6));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result_stable", 64'(result), 64'(held));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    drain(0);
    check("bp_new_operands", 64'(result), 64'(k_ext));

    // reset during the second MAC cycle
    set_ops('{1, 2, 3, 4, 5, 6}, '{1, 1, 1});
    send();
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete(); exp_sat_q.delete(); acc_cyc_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    saw_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
    end
    check("reset_no_out_valid", 64'(saw_ov), 64'd0);
    check("reset_in_ready_after", 64'(in_ready), 64'd1);
    check("reset_result_cleared", 64'(result), 64'd0);
    send(); drain(0);
    check("after_reset_case1", 64'(result), 64'(k15_6));

    // streaming: in_valid held high, out_ready tied high
    stream_mode = 1'b1;
    hs_q.delete();
    @(posedge clk); #1;
    rand_ops();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept();
      rand_ops();
    end
    in_valid = 1'b0;
    drain(0);
    stream_mode = 1'b0;
    check("stream_count", 64'(hs_q.size()), 64'd4);
    for (int i = 1; i < hs_q.size(); i++)
      check("stream_period", 64'(hs_q[i] - hs_q[i-1]), 64'(C + 2));

    // randomized traffic with random output stalls
    for (int t = 0; t < 25; t++) begin
      rand_ops();
      send();
      drain(1);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
